// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480 raster timing path.
// Defaults describe 640x480@60 Hz from a 100 MHz board clock.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam logic DEF_SYNC_ACTIVE = 1'b0;

   function automatic int seg_sum(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

   localparam int DEF_H_TOTAL = seg_sum(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = seg_sum(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
   localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

   typedef logic [COORD_W-1:0] coord_t;
   // One extra bit so window bounds equal to 1024 still compare correctly.
   typedef logic [COORD_W:0]   coord_wide_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   function automatic logic sync_level(input logic in_window, input logic active_level);
      return in_window ? active_level : ~active_level;
   endfunction

endpackage

// File: rtl/pixel_strobe.sv
// Free-running clock divider: one-clk pix_stb every CLK_DIV system clocks.
// The strobe is registered so it is low in reset even when CLK_DIV is 1.
module pixel_strobe #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_stb
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_nxt;

   always_comb begin
      div_nxt = div_cnt + DW'(1);
      if (div_cnt == DIV_LAST) begin
         div_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         pix_stb <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         pix_stb <= (div_nxt == DIV_LAST);
      end
   end

endmodule

// File: rtl/vga_timing.sv
// Raster counters, sync decode and the registered colour/sync output stage.
// vga_* lag sx/sy/hsync/vsync by one pixel so colour and sync stay aligned.
module vga_timing
   import vga_pkg::*;
#(
   parameter int   CLK_DIV     = DEF_CLK_DIV,
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               pix_stb,
   output logic [COORD_W-1:0] sx,
   output logic [COORD_W-1:0] sy,
   output logic               de,
   output logic               hsync,
   output logic               vsync,
   output logic               line_start,
   output logic               frame_start,
   input  logic [7:0]         rgb_in,
   output logic [2:0]         vga_r,
   output logic [2:0]         vga_g,
   output logic [1:0]         vga_b,
   output logic               vga_hs,
   output logic               vga_vs
);

   localparam int H_TOTAL = seg_sum(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = seg_sum(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

   localparam coord_wide_t H_ACT_END  = coord_wide_t'(H_ACTIVE);
   localparam coord_wide_t V_ACT_END  = coord_wide_t'(V_ACTIVE);
   localparam coord_wide_t H_SYNC_BEG = coord_wide_t'(H_ACTIVE + H_FP);
   localparam coord_wide_t H_SYNC_END = coord_wide_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_wide_t V_SYNC_BEG = coord_wide_t'(V_ACTIVE + V_FP);
   localparam coord_wide_t V_SYNC_END = coord_wide_t'(V_ACTIVE + V_FP + V_SYNC);

   coord_t  sx_nxt;
   coord_t  sy_nxt;
   logic    line_wrap;
   logic    frame_wrap;
   logic    de_nxt;
   logic    hs_nxt;
   logic    vs_nxt;
   rgb332_t rgb_q;

   pixel_strobe #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_strobe (
      .clk     (clk),
      .rst_n   (rst_n),
      .pix_stb (pix_stb)
   );

   // Decode is done on the next coordinate so de/hsync/vsync register
   // in the same clk as the sx/sy they describe.
   always_comb begin
      line_wrap  = (sx == H_LAST);
      frame_wrap = line_wrap && (sy == V_LAST);
      sx_nxt     = sx + coord_t'(1);
      sy_nxt     = sy;
      if (line_wrap) begin
         sx_nxt = '0;
         sy_nxt = (sy == V_LAST) ? '0 : sy + coord_t'(1);
      end
      de_nxt = (coord_wide_t'(sx_nxt) < H_ACT_END) && (coord_wide_t'(sy_nxt) < V_ACT_END);
      hs_nxt = sync_level((coord_wide_t'(sx_nxt) >= H_SYNC_BEG) &&
                          (coord_wide_t'(sx_nxt) <  H_SYNC_END), SYNC_ACTIVE);
      vs_nxt = sync_level((coord_wide_t'(sy_nxt) >= V_SYNC_BEG) &&
                          (coord_wide_t'(sy_nxt) <  V_SYNC_END), SYNC_ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sx          <= H_LAST;
         sy          <= V_LAST;
         de          <= 1'b0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_stb && line_wrap;
         frame_start <= pix_stb && frame_wrap;
         if (pix_stb) begin
            sx    <= sx_nxt;
            sy    <= sy_nxt;
            de    <= de_nxt;
            hsync <= hs_nxt;
            vsync <= vs_nxt;
         end
      end
   end

   // Colour is forced to black outside the active area regardless of rgb_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q  <= '0;
         vga_hs <= ~SYNC_ACTIVE;
         vga_vs <= ~SYNC_ACTIVE;
      end else if (pix_stb) begin
         rgb_q  <= de ? rgb332_t'(rgb_in) : '0;
         vga_hs <= hsync;
         vga_vs <= vsync;
      end
   end

   assign vga_r = rgb_q.r;
   assign vga_g = rgb_q.g;
   assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-divider/active-low and CLK_DIV=1/active-high
// instances, short vertical timing so whole frames fit the run.
module tb_vga_timing;

   localparam int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
   localparam int V_ACT = 4,   V_FP = 1,  V_SYNC = 2,  V_BP = 1;
   localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HS_LO = H_ACT + H_FP;
   localparam int HS_HI = HS_LO + H_SYNC;
   localparam int VS_LO = V_ACT + V_FP;
   localparam int VS_HI = VS_LO + V_SYNC;
   localparam int DIV0 = 4;
   localparam int DIV1 = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rgb_in = 8'h00;

   logic       pix_stb0, de0, hsync0, vsync0, ls0, fs0, vga_hs0, vga_vs0;
   logic [9:0] sx0, sy0;
   logic [2:0] vga_r0, vga_g0;
   logic [1:0] vga_b0;
   logic       pix_stb1, de1, hsync1, vsync1, ls1, fs1, vga_hs1, vga_vs1;
   logic [9:0] sx1, sy1;
   logic [2:0] vga_r1, vga_g1;
   logic [1:0] vga_b1;

   always #5 clk = ~clk;

   vga_timing #(
      .CLK_DIV(DIV0), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_ACTIVE(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb0), .sx(sx0), .sy(sy0), .de(de0),
      .hsync(hsync0), .vsync(vsync0), .line_start(ls0), .frame_start(fs0),
      .rgb_in(rgb_in), .vga_r(vga_r0), .vga_g(vga_g0), .vga_b(vga_b0),
      .vga_hs(vga_hs0), .vga_vs(vga_vs0)
   );

   vga_timing #(
      .CLK_DIV(DIV1), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_ACTIVE(1'b1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb1), .sx(sx1), .sy(sy1), .de(de1),
      .hsync(hsync1), .vsync(vsync1), .line_start(ls1), .frame_start(fs1),
      .rgb_in(rgb_in), .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1),
      .vga_hs(vga_hs1), .vga_vs(vga_vs1)
   );

   logic [35:0] obs [2];
   assign obs[0] = {pix_stb0, sx0, sy0, de0, hsync0, vsync0, ls0, fs0,
                    vga_r0, vga_g0, vga_b0, vga_hs0, vga_vs0};
   assign obs[1] = {pix_stb1, sx1, sy1, de1, hsync1, vsync1, ls1, fs1,
                    vga_r1, vga_g1, vga_b1, vga_hs1, vga_vs1};

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: position is pure arithmetic on clocks since reset release.
   int         n;
   logic [7:0] m_col [2];
   logic       m_vhs [2];
   logic       m_vvs [2];

   function automatic int div_of(input int k);
      return (k == 1) ? DIV1 : DIV0;
   endfunction

   function automatic logic sa_of(input int k);
      return (k == 1);
   endfunction

   // Number of pixel advances completed by rising edge c after release.
   function automatic int adv_count(input int c, input int d);
      if (c < 1) return 0;
      if (d == 1) return c - 1;
      return c / d;
   endfunction

   function automatic bit is_adv(input int c, input int d);
      if (c < 1) return 1'b0;
      return adv_count(c, d) != adv_count(c - 1, d);
   endfunction

   function automatic int px(input int p);
      if (p == 0) return HT - 1;
      return ((p - 1) % (HT * VT)) % HT;
   endfunction

   function automatic int py(input int p);
      if (p == 0) return VT - 1;
      return ((p - 1) % (HT * VT)) / HT;
   endfunction

   function automatic logic de_of(input int p);
      return (px(p) < H_ACT) && (py(p) < V_ACT);
   endfunction

   function automatic logic lvl(input bit on, input logic sa);
      return on ? sa : !sa;
   endfunction

   function automatic logic [35:0] exp_vec(input int k, input int c);
      int   d;
      int   p;
      int   x;
      int   y;
      logic adv_now;
      d       = div_of(k);
      p       = adv_count(c, d);
      x       = px(p);
      y       = py(p);
      adv_now = is_adv(c, d);
      return {is_adv(c + 1, d), 10'(x), 10'(y), de_of(p),
              lvl(x >= HS_LO && x < HS_HI, sa_of(k)),
              lvl(y >= VS_LO && y < VS_HI, sa_of(k)),
              adv_now && (x == 0), adv_now && (x == 0) && (y == 0),
              m_col[k], m_vhs[k], m_vvs[k]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n <= 0;
         for (int k = 0; k < 2; k++) begin
            m_col[k] <= 8'h00;
            m_vhs[k] <= !sa_of(k);
            m_vvs[k] <= !sa_of(k);
         end
      end else begin
         n <= n + 1;
         for (int k = 0; k < 2; k++) begin
            if (is_adv(n + 1, div_of(k))) begin
               m_col[k] <= de_of(adv_count(n, div_of(k))) ? rgb_in : 8'h00;
               m_vhs[k] <= lvl(px(adv_count(n, div_of(k))) >= HS_LO &&
                               px(adv_count(n, div_of(k))) <  HS_HI, sa_of(k));
               m_vvs[k] <= lvl(py(adv_count(n, div_of(k))) >= VS_LO &&
                               py(adv_count(n, div_of(k))) <  VS_HI, sa_of(k));
            end
         end
      end
   end

   // Event recorder: observed timing, judged later against spec constants.
   bit   rec_en = 1'b1;
   int   ls0_last = -1, ls0_prev = -1, fs0_last = -1, fs0_prev = -1;
   int   ls1_last = -1, ls1_prev = -1;
   int   hs0_fall = -1, vhs0_fall = -1, hs0_low_line0 = 0;
   int   hs0_min = 9999, hs0_max = -1, hs1_min = 9999, hs1_max = -1;
   int   vs0_min = 9999, vs0_max = -1, de0_xmax = -1, de0_ymax = -1;
   logic hs0_d = 1'b1, vhs0_d = 1'b1;

   always @(negedge clk) begin
      if (rst_n && rec_en) begin
         hs0_d  <= hsync0;
         vhs0_d <= vga_hs0;
         if (ls0) begin ls0_prev <= ls0_last; ls0_last <= n; end
         if (fs0) begin fs0_prev <= fs0_last; fs0_last <= n; end
         if (ls1) begin ls1_prev <= ls1_last; ls1_last <= n; end
         if (hs0_d && !hsync0 && hs0_fall < 0) hs0_fall <= n;
         if (vhs0_d && !vga_hs0 && vhs0_fall < 0) vhs0_fall <= n;
         if (!hsync0 && n < 4 + HT * DIV0) hs0_low_line0 <= hs0_low_line0 + 1;
         if (!hsync0 && int'(sx0) < hs0_min) hs0_min <= int'(sx0);
         if (!hsync0 && int'(sx0) > hs0_max) hs0_max <= int'(sx0);
         if (hsync1 && int'(sx1) < hs1_min) hs1_min <= int'(sx1);
         if (hsync1 && int'(sx1) > hs1_max) hs1_max <= int'(sx1);
         if (!vsync0 && int'(sy0) < vs0_min) vs0_min <= int'(sy0);
         if (!vsync0 && int'(sy0) > vs0_max) vs0_max <= int'(sy0);
         if (de0 && int'(sx0) > de0_xmax) de0_xmax <= int'(sx0);
         if (de0 && int'(sy0) > de0_ymax) de0_ymax <= int'(sy0);
      end
   end

   task automatic wait_xy0(input int x, input int y0, input int y1, output bit ok);
      ok = 1'b0;
      for (int g = 0; g < 40000 && !ok; g++) begin
         @(negedge clk);
         if (is_adv(n, DIV0) && px(adv_count(n, DIV0)) == x &&
             py(adv_count(n, DIV0)) >= y0 && py(adv_count(n, DIV0)) <= y1)
            ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rgb_in = 8'($urandom);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k, 0)) begin
               n_err++;
               $display("FAIL reset dut%0d: got %h expected %h", k, obs[k], exp_vec(k, 0));
            end
         end
      end
   endtask

   task automatic test_first_frame();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp += 2;
         if (fs0 !== (n == 4)) begin
            n_err++;
            $display("FAIL first_fs0 clk %0d: got %b expected %b", n, fs0, (n == 4));
         end
         if (fs1 !== (n == 2)) begin
            n_err++;
            $display("FAIL first_fs1 clk %0d: got %b expected %b", n, fs1, (n == 2));
         end
         if (n == 4) begin
            n_cmp++;
            if ({sx0, sy0, de0, ls0} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
               n_err++;
               $display("FAIL first_pixel0: got sx=%0d sy=%0d de=%b ls=%b expected 0 0 1 1",
                        sx0, sy0, de0, ls0);
            end
         end
      end
   endtask

   task automatic test_raster();
      for (int i = 0; i < 25700; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k, n)) begin
               n_err++;
               if (n_err < 30)
                  $display("FAIL raster dut%0d clk %0d: got %h expected %h",
                           k, n, obs[k], exp_vec(k, n));
            end
         end
         rgb_in = 8'($urandom);
      end
   endtask

   task automatic test_periods();
      int got [13];
      int req [13];
      got = '{ls0_last - ls0_prev, fs0_last - fs0_prev, ls1_last - ls1_prev, hs0_low_line0,
              hs0_min, hs0_max, hs1_min, hs1_max, vs0_min, vs0_max,
              vhs0_fall - hs0_fall, de0_xmax, de0_ymax};
      req = '{HT * DIV0, HT * VT * DIV0, HT * DIV1, H_SYNC * DIV0,
              HS_LO, HS_HI - 1, HS_LO, HS_HI - 1, VS_LO, VS_HI - 1,
              DIV0, H_ACT - 1, V_ACT - 1};
      for (int i = 0; i < 13; i++) begin
         n_cmp++;
         if (got[i] !== req[i]) begin
            n_err++;
            $display("FAIL period_item%0d: got %0d expected %0d", i, got[i], req[i]);
         end
      end
   endtask

   task automatic test_colour();
      bit ok;
      int xs [4] = '{1, 640, 641, 1};
      int ys [4] = '{1, 1, 1, 4};
      logic [7:0] want [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
      rgb_in = 8'hFF;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         wait_xy0(xs[i], ys[i], ys[i], ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL colour_wait%0d: got timeout expected sx=%0d sy=%0d", i, xs[i], ys[i]);
         end else if ({vga_r0, vga_g0, vga_b0} !== want[i]) begin
            n_err++;
            $display("FAIL colour_at_%0d_%0d: got %h expected %h",
                     xs[i], ys[i], {vga_r0, vga_g0, vga_b0}, want[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      wait_xy0(700, 2, 2, ok);
      rec_en = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL midreset_wait: got timeout expected sx=700 sy=2");
      end
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== exp_vec(k, 0)) begin
            n_err++;
            $display("FAIL midreset_async dut%0d: got %h expected %h", k, obs[k], exp_vec(k, 0));
         end
      end
      n_cmp++;
      if ({sx0, vga_hs0, hsync0} !== {10'(HT - 1), 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL midreset_sx_sync0: got sx=%0d vhs=%b hs=%b expected %0d 1 1",
                  sx0, vga_hs0, hsync0, HT - 1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (fs0 !== (n == 4)) begin
            n_err++;
            $display("FAIL restart_fs0 clk %0d: got %b expected %b", n, fs0, (n == 4));
         end
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k, n)) begin
               n_err++;
               $display("FAIL restart dut%0d clk %0d: got %h expected %h",
                        k, n, obs[k], exp_vec(k, n));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_raster();
      test_periods();
      test_colour();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480@60 Hz display path. It produces the `sx`/`sy` pixel coordinates and active-area flag consumed by the combinational `screen` renderer, then registers the renderer's colour output together with the sync pulses so that colour and sync reach the VGA connector aligned. It sits between the board clock and the `screen` block.

## Interface

Parameters:

- `CLK_DIV`, default 4: system clocks per pixel (100 MHz → 25 MHz); must be ≥ 1.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal segment lengths in pixels.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical segment lengths in lines.
- `SYNC_ACTIVE`, default 0: asserted level of `hsync`/`vsync` and `vga_hs`/`vga_vs` (0 means active-low).

Ports:

- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pix_stb` output 1: one-`clk` pixel enable.
- `sx` output 10: current column, 0..H_TOTAL-1.
- `sy` output 10: current row, 0..V_TOTAL-1.
- `de` output 1: high when sx < H_ACTIVE and sy < V_ACTIVE.
- `hsync` output 1: raw horizontal sync, aligned with `sx`.
- `vsync` output 1: raw vertical sync, aligned with `sy`.
- `line_start` output 1: one-`clk` pulse when `sx` becomes 0.
- `frame_start` output 1: one-`clk` pulse when (`sx`,`sy`) becomes (0,0).
- `rgb_in` input 8: {r[2:0], g[2:0], b[1:0]} from `screen` for the current `sx`/`sy`.
- `vga_r` output 3, `vga_g` output 3, `vga_b` output 2: registered colour.
- `vga_hs` output 1, `vga_vs` output 1: registered sync, aligned with colour.

## Operation

- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024 so they fit 10 bits.
- Divider: counts 0..CLK_DIV-1 and wraps. `pix_stb` is high in the `clk` where the count equals CLK_DIV-1. With CLK_DIV=1, `pix_stb` is constantly high.
- On each `pix_stb`, `sx` increments.
  - When `sx` = H_TOTAL-1, `sx` goes to 0 and `sy` increments.
  - When `sy` = V_TOTAL-1 at that point, `sy` goes to 0.
- `hsync` = SYNC_ACTIVE while H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise it is the inverse level.
- `vsync` = SYNC_ACTIVE while V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise it is the inverse level.
- Output stage: on `pix_stb`, the block registers `rgb_in` into `vga_r/g/b` when `de` is high and registers 0 otherwise. `hsync`/`vsync` are registered into `vga_hs`/`vga_vs` in the same `clk`.
- The block never drives colour outside the active area, whatever `rgb_in` holds.

## Timing

- Reset values:
  - divider = 0, `pix_stb` = 0.
  - `sx` = H_TOTAL-1, `sy` = V_TOTAL-1, `de` = 0, so the first `pix_stb` moves to (0,0).
  - `hsync`/`vsync`/`vga_hs`/`vga_vs` = inactive level (1 for defaults).
  - colour = 0, `line_start` = `frame_start` = 0.
- `sx`, `sy`, `de`, `hsync`, `vsync`, `line_start`, `frame_start` are all registered. They change in the `clk` after the `pix_stb` that advanced them and hold for CLK_DIV clocks.
- `line_start`/`frame_start` are high for exactly one `clk`: the first `clk` of the new coordinate. `frame_start` implies `line_start`.
- First `pix_stb` after reset release: with defaults, this is `clk` #4 (the 4th rising edge). The next `clk` shows sx=0, sy=0, de=1, line_start=1, frame_start=1.
- Pipeline latency: `vga_*` lag `sx`/`sy`/`hsync`/`vsync` by exactly one pixel period. Colour and sync at the connector are mutually aligned.
- `rst_n` asserted mid-frame: all state returns to reset values immediately (asynchronous). No partial sync pulse is held.

## Structure

- Package `vga_pkg`: default timing constants, derived `H_TOTAL`/`V_TOTAL`, sync-window bounds, and the `SYNC_ACTIVE` default.
- Sub-module `pixel_strobe`: parameterised divider producing `pix_stb`.
- Counters, sync decode and output registers live in `vga_timing` itself.

## Test plan

- Reset then run with defaults: the first `frame_start` occurs 4 `clk` after release. Thereafter `frame_start` period = 800·525·4 = 1,680,000 `clk`. `line_start` period = 3200 `clk`.
- Horizontal sync: `hsync` low for exactly 96 pixel periods, from sx=656 to sx=751. `de` high for sx 0..639 only.
- Vertical sync: `vsync` low on sy=490 and sy=491 only. `de` = 0 for all sy ≥ 480, including sx < 640.
- Colour gating and alignment: hold `rgb_in` = 8'hFF.
  - `vga_r`=7, `vga_g`=7, `vga_b`=3 from one pixel after (0,0) through one pixel after (639,y).
  - Colour is 0 elsewhere.
  - The `vga_hs` falling edge lands one pixel after `hsync`.
- Mid-frame reset: assert `rst_n`=0 at sx=700, sy=300. Outputs go to reset values in the same cycle. After release, the frame restarts at (0,0) with `frame_start`.
- Parameter corner: with CLK_DIV=1 and SYNC_ACTIVE=1, `pix_stb` is constant 1, `hsync` is high for sx 656..751, and `line_start` period = 800 `clk`.
